// File: rtl/seq_byte_fifo.sv
// seq_byte_fifo: byte FIFO that turns a raw write-strobe stream into a valid/ready stream and counts overflow drops
module seq_byte_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    output logic [7:0]    data_out,
    output logic          valid_out,
    input  logic          ready_in,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic [7:0]    drop_count,
    input  logic          clr_drop
);
    localparam logic [AW:0] LP_DEPTH = (AW + 1)'(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [7:0]  r_drop;
    logic [AW:0] w_level;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;

    // occupancy and handshake decodes; valid depends only on registered pointers
    always_comb begin
        w_level    = r_wr_ptr - r_rd_ptr;
        w_full     = w_level == LP_DEPTH;
        w_empty    = w_level == '0;
        w_pop      = !w_empty && ready_in;
        w_push     = wr_en && (!w_full || w_pop);
        w_drop     = wr_en && w_full && !w_pop;
        valid_out  = !w_empty;
        data_out   = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
        level      = w_level;
        full       = w_full;
        empty      = w_empty;
        drop_count = r_drop;
    end

    // storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

    // pointer advance on push/pop, wrapping modulo 2*DEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // saturating drop counter; a drop coinciding with clear counts as one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                        r_drop <= 8'h00;
        else if (clr_drop)                 r_drop <= w_drop ? 8'h01 : 8'h00;
        else if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'h01;
    end
endmodule

// File: tb/tb_seq_byte_fifo.sv
// tb_seq_byte_fifo: scoreboard bench for seq_byte_fifo
module tb_seq_byte_fifo;
    localparam int DEPTH = 8;

    logic       clk = 0;
    logic       reset = 0;
    logic [7:0] wr_data = 0;
    logic       wr_en = 0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_in = 0;
    logic [3:0] level;
    logic       full;
    logic       empty;
    logic [7:0] drop_count;
    logic       clr_drop = 0;

    int         total = 0;
    int         bad = 0;
    logic [7:0] q[$];
    logic [7:0] m_drop = 0;
    logic       m_pop, m_full, m_push, m_drop_ev, exp_v;
    logic [7:0] exp_d;
    logic [3:0] exp_lvl;

    seq_byte_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
        .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
        .level(level), .full(full), .empty(empty),
        .drop_count(drop_count), .clr_drop(clr_drop)
    );

    always #5 clk = ~clk;

    // scoreboard: compare every cycle at negedge, then advance the model for the coming edge
    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
            m_drop = 0;
            total++;
            if (valid_out !== 1'b0 || data_out !== 8'h00 || level !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || drop_count !== 8'h00) begin
                bad++;
                $display("FAIL reset_state: v=%b d=%h lvl=%0d e=%b f=%b drop=%0d want v=0 d=00 lvl=0 e=1 f=0 drop=0",
                         valid_out, data_out, level, empty, full, drop_count);
            end
        end else begin
            exp_v   = q.size() != 0;
            exp_d   = exp_v ? q[0] : 8'h00;
            exp_lvl = 4'(q.size());
            total++;
            if (valid_out !== exp_v || data_out !== exp_d || level !== exp_lvl || full !== (q.size() == DEPTH) || empty !== !exp_v || drop_count !== m_drop) begin
                bad++;
                $display("FAIL scoreboard t=%0t: v=%b d=%h lvl=%0d f=%b e=%b drop=%0d want v=%b d=%h lvl=%0d f=%b e=%b drop=%0d",
                         $time, valid_out, data_out, level, full, empty, drop_count,
                         exp_v, exp_d, exp_lvl, q.size() == DEPTH, !exp_v, m_drop);
            end
            m_pop     = exp_v && ready_in;
            m_full    = q.size() == DEPTH;
            m_push    = wr_en && (!m_full || m_pop);
            m_drop_ev = wr_en && m_full && !m_pop;
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(wr_data);
            if (clr_drop) m_drop = m_drop_ev ? 8'h01 : 8'h00;
            else if (m_drop_ev && m_drop != 8'hFF) m_drop = m_drop + 8'h01;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        ready_in = 1;
        wr_en = 0;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: left=%0d want 0", q.size());
        end
        step();
        total++;
        if (valid_out !== 1'b0 || empty !== 1'b1) begin
            bad++;
            $display("FAIL drain_empty: v=%b e=%b want v=0 e=1", valid_out, empty);
        end
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (3) step();
        reset = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (valid_out !== 1'b0 || data_out !== 8'h00 || level !== 4'd0 || empty !== 1'b1 || drop_count !== 8'h00) begin
                bad++;
                $display("FAIL idle_after_reset: v=%b d=%h lvl=%0d e=%b drop=%0d want 0/00/0/1/0",
                         valid_out, data_out, level, empty, drop_count);
            end
        end
    endtask

    task automatic test_latency();
        wr_en = 1; wr_data = 8'hA5; ready_in = 1;
        step();
        wr_en = 0;
        total++;
        if (valid_out !== 1'b1 || data_out !== 8'hA5) begin
            bad++;
            $display("FAIL latency: v=%b d=%h want v=1 d=a5", valid_out, data_out);
        end
        step();
        total++;
        if (empty !== 1'b1 || valid_out !== 1'b0) begin
            bad++;
            $display("FAIL latency_pop: e=%b v=%b want e=1 v=0", empty, valid_out);
        end
    endtask

    task automatic test_fill_overflow();
        ready_in = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 9) begin
                total++;
                if (full !== 1'b1 || level !== 4'd8) begin
                    bad++;
                    $display("FAIL full_after_8: f=%b lvl=%0d want f=1 lvl=8", full, level);
                end
            end
            wr_en = 1; wr_data = 8'(i);
        end
        step();
        wr_en = 0;
        total++;
        if (drop_count !== 8'd2) begin
            bad++;
            $display("FAIL overflow_drops: drop=%0d want 2", drop_count);
        end
        drain();
    endtask

    task automatic test_full_push_pop();
        logic [7:0] d0;
        ready_in = 0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1; wr_data = 8'h10 + 8'(i);
            step();
        end
        wr_en = 0;
        d0 = drop_count;
        total++;
        if (level !== 4'd8) begin
            bad++;
            $display("FAIL prefill_level: lvl=%0d want 8", level);
        end
        wr_en = 1; wr_data = 8'hFF; ready_in = 1;
        step();
        wr_en = 0; ready_in = 0;
        total++;
        if (level !== 4'd8 || drop_count !== d0 || data_out !== 8'h11) begin
            bad++;
            $display("FAIL full_push_pop: lvl=%0d drop=%0d head=%h want lvl=8 drop=%0d head=11", level, drop_count, data_out, d0);
        end
        drain();
    endtask

    task automatic test_saturation();
        ready_in = 0;
        wr_en = 1;
        for (int i = 0; i < 308; i++) begin
            wr_data = 8'(i);
            step();
        end
        wr_en = 0;
        total++;
        if (drop_count !== 8'hFF) begin
            bad++;
            $display("FAIL drop_saturate: drop=%h want ff", drop_count);
        end
        wr_en = 1; clr_drop = 1; wr_data = 8'h77;
        step();
        wr_en = 0; clr_drop = 0;
        total++;
        if (drop_count !== 8'h01) begin
            bad++;
            $display("FAIL clr_with_drop: drop=%h want 01", drop_count);
        end
        clr_drop = 1;
        step();
        clr_drop = 0;
        drain();
    endtask

    task automatic test_wrap_reset();
        for (int i = 0; i < 40; i++) begin
            ready_in = i[0];
            wr_en = !i[0];
            wr_data = 8'h40 + 8'(i / 2);
            step();
        end
        drain();
        ready_in = 0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1; wr_data = 8'hC0 + 8'(i);
            step();
        end
        wr_en = 0;
        total++;
        if (level !== 4'd3 || valid_out !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_level: lvl=%0d v=%b want lvl=3 v=1", level, valid_out);
        end
        #2 reset = 0;
        #1;
        total++;
        if (valid_out !== 1'b0 || level !== 4'd0 || data_out !== 8'h00) begin
            bad++;
            $display("FAIL async_reset: v=%b lvl=%0d d=%h want v=0 lvl=0 d=00", valid_out, level, data_out);
        end
        step();
        step();
        #3 reset = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (valid_out !== 1'b0 || level !== 4'd0) begin
                bad++;
                $display("FAIL post_reset_idle: v=%b lvl=%0d want v=0 lvl=0", valid_out, level);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill_overflow();
        test_full_push_pop();
        test_saturation();
        test_wrap_reset();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
